// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader that fills instruction memory and releases core reset on a good checksum
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_cpu_rst_n,
    output logic                  o_load_done,
    output logic                  o_load_err
);
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t                r_state;
    logic [15:0]           r_len;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH:0]   r_widx;
    logic [1:0]            r_bidx;
    logic [23:0]           r_word;
    logic                  r_in_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_load_done;
    logic                  r_load_err;

    logic        w_fire;
    logic        w_sync;
    logic [15:0] w_len;

    assign w_fire = i_in_valid && r_in_ready;
    assign w_sync = i_in_data == 8'hA5;
    assign w_len  = {i_in_data, r_len[7:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_csum       <= '0;
            r_widx       <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst_n  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            r_imem_we  <= 1'b0;
            if (w_fire) begin
                r_csum <= r_csum ^ i_in_data;
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (w_sync) begin
                            r_state     <= S_LEN0;
                            r_csum      <= '0;
                            r_widx      <= '0;
                            r_bidx      <= '0;
                            r_cpu_rst_n <= 1'b0;
                            r_load_done <= 1'b0;
                            r_load_err  <= 1'b0;
                        end
                    end
                    S_LEN0: begin
                        r_len[7:0] <= i_in_data;
                        r_state    <= S_LEN1;
                    end
                    S_LEN1: begin
                        r_len[15:8] <= i_in_data;
                        if (32'(w_len) > (32'd1 << ADDR_WIDTH)) begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state <= (w_len == 16'd0) ? S_CSUM : S_DATA;
                        end
                    end
                    S_DATA: begin
                        // bytes arrive LSB first, so shifting in from the top leaves lane 0 lowest
                        r_word <= {i_in_data, r_word[23:8]};
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_widx[ADDR_WIDTH-1:0];
                            r_imem_wdata <= {i_in_data, r_word};
                            r_widx       <= r_widx + 1'b1;
                            if (32'(r_widx) + 32'd1 == 32'(r_len))
                                r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (i_in_data == r_csum) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_cpu_rst_n <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_cpu_rst_n  = r_cpu_rst_n;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus against a word-list reference of the expected memory image and flags
module tb_imem_loader;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_cpu_rst_n (cpu_rst_n),
        .o_load_done (load_done),
        .o_load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int maxgap  = 0;
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];

    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err);
        check({tag, ".done"}, 32'(load_done), 32'(done));
        check({tag, ".err"}, 32'(load_err), 32'(err));
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 32'(in_ready), 0);
        check({tag, ".we"}, 32'(imem_we), 0);
        check({tag, ".addr"}, 32'(imem_addr), 0);
        check({tag, ".wdata"}, imem_wdata, 0);
        check_flags(tag, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // expected image is the word list itself; checksum is the XOR rule over length and data bytes
    task automatic run_frame(input int n, input bit bad);
        logic [31:0] w[$];
        logic [31:0] wd;
        logic [15:0] len;
        logic [7:0]  x;
        got_addr.delete();
        got_data.delete();
        len = 16'(n);
        check("frame.ready", 32'(in_ready), 1);
        send(8'hA5);
        check_flags("sync", 1'b0, 1'b0);
        x = len[7:0] ^ len[15:8];
        send(len[7:0]);
        send(len[15:8]);
        for (int k = 0; k < n; k++) begin
            wd = $urandom;
            w.push_back(wd);
            for (int b = 0; b < 4; b++) begin
                x ^= wd[8*b +: 8];
                send(wd[8*b +: 8]);
            end
            check("wr.we", 32'(imem_we), 1);
            check("wr.addr", 32'(imem_addr), 32'(k));
            check("wr.data", imem_wdata, wd);
        end
        send(bad ? x ^ 8'($urandom_range(255, 1)) : x);
        check_flags(bad ? "bad_csum" : "good_csum", !bad, bad);
        idle(2);
        check("writes.count", 32'(got_addr.size()), 32'(n));
        for (int k = 0; k < n && k < got_addr.size(); k++) begin
            check("img.addr", 32'(got_addr[k]), 32'(k));
            check("img.data", got_data[k], w[k]);
        end
        check_flags("settled", !bad, bad);
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(in_ready), 1);

        // known single-word program: addi x1, x0, 42
        got_addr.delete();
        got_data.delete();
        send_list('{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h02});
        check("single.we", 32'(imem_we), 1);
        check("single.data", imem_wdata, 32'h02A00093);
        send(8'h30);
        check_flags("single", 1'b1, 1'b0);
        idle(2);
        check("single.count", 32'(got_addr.size()), 1);

        got_addr.delete();
        got_data.delete();
        send(8'hA5);
        check_flags("restart", 1'b0, 1'b0);
        send_list('{8'h01, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h02, 8'h31});
        check_flags("badsum", 1'b0, 1'b1);
        idle(2);
        check("badsum.count", 32'(got_addr.size()), 1);

        got_addr.delete();
        got_data.delete();
        send_list('{8'hA5, 8'h11, 8'h00});
        check_flags("overflow", 1'b0, 1'b1);
        send_list('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
        idle(2);
        check_flags("overflow.junk", 1'b0, 1'b1);
        check("overflow.count", 32'(got_addr.size()), 0);

        send_list('{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00});
        check_flags("zero_len", 1'b1, 1'b0);
        idle(2);
        check("zero_len.count", 32'(got_addr.size()), 0);

        run_frame(16, 1'b0);

        maxgap = 5;
        run_frame(3, 1'b0);
        run_frame(3, 1'b0);
        for (int i = 0; i < 8; i++)
            run_frame(int'($urandom_range(6, 1)), $urandom_range(3, 0) == 0);
        maxgap = 0;

        send_list('{8'hA5, 8'h03, 8'h00});
        for (int i = 0; i < 6; i++) send(8'($urandom_range(255, 1)));
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream boot loader for the single-cycle RV32I core. It receives a framed program image over a valid/ready byte interface and writes it word by word into instruction memory starting at word address 0. The core is held in reset through its own reset output until a complete frame with a correct checksum has been written. This replaces hierarchical pre-loading of `mem[]` in benches and is the path used on hardware.

## Interface
- `ADDR_WIDTH`, 10: instruction-memory word-address width; max image = 2^ADDR_WIDTH words.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge where `in_valid && in_ready`.
- `imem_we`  out  1  one-cycle word write strobe to instruction memory.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  word to write.
- `cpu_rst_n`  out  1  active-low reset to the core; high only in DONE.
- `load_done`  out  1  frame loaded and checksum matched.
- `load_err`  out  1  frame rejected (length overflow or checksum mismatch).

## Operation
- Frame: sync byte `0xA5`, LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes (each word little-endian, LSB first), then CSUM.
- CSUM = XOR of LEN_LO, LEN_HI and all data bytes (sync excluded). N=0 gives expected CSUM `0x00`.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: sync byte -> LEN0; any other byte dropped.
  - LEN0: store LEN_LO -> LEN1.
  - LEN1: store LEN_HI; if N > 2^ADDR_WIDTH -> ERR; if N == 0 -> CSUM; else -> DATA, byte index 0, word index 0.
  - DATA: shift byte into word assembly register at lane (byte index mod 4); on 4th byte issue write at current word index, increment word index; after word N-1 written -> CSUM.
  - CSUM: match -> DONE; mismatch -> ERR.
  - DONE / ERR: sync byte -> LEN0 (restart, clears flags, reasserts core reset); other bytes dropped.
- Running XOR and counters cleared on every sync acceptance.
- Words are written as they arrive; a later checksum failure does not undo writes but keeps the core in reset.
- Word index width ADDR_WIDTH+1 internally; `imem_addr` = low ADDR_WIDTH bits (never wraps because of the overflow check).

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst_n`=0, `load_done`=0, `load_err`=0; state IDLE; partial word and counters discarded.
- `in_ready` registered: 1 from the first edge after `rst_n` release, thereafter constantly 1 (no back-pressure; one byte per cycle sustained).
- Write latency: 4th byte of word k accepted at edge t -> `imem_we`=1, `imem_addr`=k, `imem_wdata`=assembled word during cycle t..t+1; `imem_we` low otherwise. `imem_addr`/`imem_wdata` hold last values between strobes.
- CSUM byte accepted at edge t -> from edge t: `load_done`=1 and `cpu_rst_n`=1 (match), or `load_err`=1 (mismatch). Overflow: `load_err`=1 from edge accepting LEN_HI.
- Restart sync in DONE/ERR accepted at edge t -> `cpu_rst_n`=0, `load_done`=0, `load_err`=0 from edge t.
- `in_valid` gaps between bytes of any length have no effect on result.
- `rst_n` asserted mid-frame: all outputs to reset values immediately (asynchronous); loader returns to IDLE awaiting a new sync.

## Test plan
- Single word: A5 01 00 93 00 A0 02 30 -> one `imem_we` pulse, addr 0, data `0x02A00093`; then `cpu_rst_n`=1, `load_done`=1; core run 10 cycles gives x1 = 42.
- Bad checksum: same frame with CSUM 31 -> word written, `load_err`=1, `load_done`=0, `cpu_rst_n` stays 0.
- Overflow (ADDR_WIDTH=4): A5 11 00 -> `load_err`=1 after LEN_HI, no `imem_we`; following bytes ignored until next A5.
- Zero length plus junk: 00 FF 12 A5 00 00 00 -> junk dropped, no writes, `load_done`=1.
- Multi-word with gaps and reload: 3-word frame, random 0-5 cycle `in_valid` gaps -> writes at addr 0,1,2 with correct words; then A5 in DONE -> `cpu_rst_n`=0 next edge, second frame loads correctly.
- Reset mid-DATA: drop `rst_n` after 6 data bytes -> all outputs reset values immediately; after release a full frame loads with first write at addr 0.
